// File: rtl/lif_neuron_bank.sv
// Bank of leaky integrate-and-fire neurons: psums accumulate per channel while idle,
// and a transit pulse sweeps the channels one per cycle to leak, integrate and fire.
module lif_lane #(
  parameter int BIT_WIDTH  = 32,
  parameter int THRESHOLD  = 100,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 add_en,
  input  logic                 fire_en,
  input  logic [31:0]          psum,
  output logic [BIT_WIDTH-1:0] acc,
  output logic [BIT_WIDTH-1:0] mem,
  output logic                 spike
);
  // Two guard bits so every sum is exact before saturation.
  localparam int EW = ((BIT_WIDTH > 32) ? BIT_WIDTH : 32) + 2;
  localparam logic signed [EW-1:0] MAXV = EW'({(BIT_WIDTH-1){1'b1}});
  localparam logic signed [EW-1:0] MINV = -MAXV - 1;
  localparam logic signed [EW-1:0] TH   = EW'(THRESHOLD);

  function automatic logic [BIT_WIDTH-1:0] sat(input logic signed [EW-1:0] v);
    if (v > MAXV)      sat = MAXV[BIT_WIDTH-1:0];
    else if (v < MINV) sat = MINV[BIT_WIDTH-1:0];
    else               sat = v[BIT_WIDTH-1:0];
  endfunction

  logic signed [EW-1:0]  acc_x, mem_x, psum_x, m_raw, m_x;
  logic [BIT_WIDTH-1:0]  m_sat;

  always_comb begin
    acc_x  = {{(EW-BIT_WIDTH){acc[BIT_WIDTH-1]}}, acc};
    mem_x  = {{(EW-BIT_WIDTH){mem[BIT_WIDTH-1]}}, mem};
    psum_x = {{(EW-32){psum[31]}}, psum};
    m_raw  = mem_x - (mem_x >>> LEAK_SHIFT) + acc_x;
    m_sat  = sat(m_raw);
    m_x    = {{(EW-BIT_WIDTH){m_sat[BIT_WIDTH-1]}}, m_sat};
    spike  = (m_x >= TH);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      acc <= '0;
      mem <= '0;
    end else if (fire_en) begin
      mem <= spike ? (m_sat - TH[BIT_WIDTH-1:0]) : m_sat;
      acc <= '0;
    end else if (add_en) begin
      acc <= sat(acc_x + psum_x);
    end
  end
endmodule

module lif_neuron_bank #(
  parameter int OUT_CHANNELS = 2,
  parameter int BIT_WIDTH    = 32,
  parameter int THRESHOLD    = 100,
  parameter int LEAK_SHIFT   = 3,
  localparam int IW = $clog2(OUT_CHANNELS) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             psum_in,
  input  logic                    psum_valid,
  input  logic [IW-1:0]           oc_idx,
  input  logic                    transit,
  input  logic                    sample_rst,
  output logic [OUT_CHANNELS-1:0] spike_out,
  output logic                    spike_valid,
  output logic                    busy,
  output logic                    err_overrun
);
  localparam int CW = (OUT_CHANNELS > 1) ? $clog2(OUT_CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, FIRE, DONE} state_t;
  state_t state, state_n;

  logic [CW-1:0]                          ch_cnt;
  logic [OUT_CHANNELS-1:0]                spike_buf, spike_w;
  logic [OUT_CHANNELS-1:0][BIT_WIDTH-1:0] acc_q, mem_q;

  assign busy = (state != IDLE);

  genvar i;
  generate
    for (i = 0; i < OUT_CHANNELS; i++) begin : g_lane
      lif_lane #(
        .BIT_WIDTH(BIT_WIDTH), .THRESHOLD(THRESHOLD), .LEAK_SHIFT(LEAK_SHIFT)
      ) u_lane (
        .clk    (clk),
        .clr    (rst | sample_rst),
        .add_en (state == IDLE && psum_valid && oc_idx == IW'(i)),
        .fire_en(state == FIRE && ch_cnt == CW'(i)),
        .psum   (psum_in),
        .acc    (acc_q[i]),
        .mem    (mem_q[i]),
        .spike  (spike_w[i])
      );
    end
  endgenerate

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (transit) state_n = FIRE;
      FIRE:    if (ch_cnt == CW'(OUT_CHANNELS-1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // sample_rst aborts a sweep but not a sweep being started from idle.
    if (sample_rst && state != IDLE) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ch_cnt      <= '0;
      spike_buf   <= '0;
      spike_out   <= '0;
      spike_valid <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state       <= state_n;
      spike_valid <= 1'b0;
      if (state != IDLE && (psum_valid || transit)) err_overrun <= 1'b1;
      case (state)
        IDLE: ch_cnt <= '0;
        FIRE: begin
          ch_cnt            <= ch_cnt + 1'b1;
          spike_buf[ch_cnt] <= spike_w[ch_cnt];
        end
        DONE: if (!sample_rst) begin
          spike_out   <= spike_buf;
          spike_valid <= 1'b1;
        end
        default: ch_cnt <= '0;
      endcase
    end
  end
endmodule

// File: tb/tb_lif_neuron_bank.sv
// Randomized bench for lif_neuron_bank: a timestep-level model predicts each sweep
// result into a queue, and a negedge monitor checks outputs against it.
module tb_lif_neuron_bank;
  localparam int N  = 4;
  localparam int TH = 100;
  localparam int LS = 3;

  logic clk = 0, rst = 1, psum_valid = 0, transit = 0, sample_rst = 0;
  logic [31:0] psum_in = 0;
  logic [2:0]  oc_idx = 0;
  logic [N-1:0] spike_out;
  logic spike_valid, busy, err_overrun;

  lif_neuron_bank #(.OUT_CHANNELS(N), .BIT_WIDTH(32), .THRESHOLD(TH), .LEAK_SHIFT(LS)) dut (
    .clk(clk), .rst(rst), .psum_in(psum_in), .psum_valid(psum_valid), .oc_idx(oc_idx),
    .transit(transit), .sample_rst(sample_rst), .spike_out(spike_out),
    .spike_valid(spike_valid), .busy(busy), .err_overrun(err_overrun));

  always #5 clk = ~clk;

  typedef struct packed {
    int              due;
    logic [N-1:0]    sp;
    logic [N-1:0][31:0] mem;
  } exp_t;

  exp_t   q[$];
  exp_t   pend;
  longint m_acc[N], m_mem[N];
  int     busy_left = 0;
  bit     m_err = 0;
  logic [N-1:0] m_spout = 0;
  int     cyc = 0;
  int     n_chk = 0, n_pass = 0;
  bit     mon_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  function automatic longint sat32(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  // Leak is floor(mem / 2^LS).
  function automatic longint leak(input longint v);
    longint d, r;
    d = longint'(1) << LS;
    r = v / d;
    if ((v % d) != 0 && v < 0) r = r - 1;
    return r;
  endfunction

  task automatic zero_state();
    for (int i = 0; i < N; i++) begin m_acc[i] = 0; m_mem[i] = 0; end
  endtask

  task automatic sweep();
    longint m;
    pend = '0;
    for (int i = 0; i < N; i++) begin
      m = sat32(m_mem[i] - leak(m_mem[i]) + m_acc[i]);
      if (m >= TH) begin pend.sp[i] = 1'b1; m_mem[i] = m - TH; end
      else m_mem[i] = m;
      m_acc[i] = 0;
      pend.mem[i] = m_mem[i][31:0];
    end
  endtask

  // One clock edge: drive inputs, then advance the model as of that edge.
  task automatic step(input bit r, input bit v, input int idx, input longint p,
                      input bit tr, input bit sr);
    rst = r; psum_valid = v; oc_idx = 3'(idx); psum_in = p[31:0];
    transit = tr; sample_rst = sr;
    @(posedge clk);
    cyc++;
    if (r) begin
      zero_state(); busy_left = 0; m_err = 0; m_spout = '0; q.delete();
    end else if (busy_left > 0) begin
      if (v || tr) m_err = 1;
      if (sr) begin zero_state(); busy_left = 0; end
      else begin
        busy_left--;
        if (busy_left == 0) begin pend.due = cyc; q.push_back(pend); m_spout = pend.sp; end
      end
    end else begin
      if (sr) zero_state();
      else if (v && idx < N) m_acc[idx] = sat32(m_acc[idx] + p);
      if (tr) begin sweep(); busy_left = N + 1; end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) if (mon_en) begin
    exp_t e;
    chk("busy", 64'(busy), 64'(busy_left > 0));
    chk("err_overrun", 64'(err_overrun), 64'(m_err));
    chk("spike_out_hold", 64'(spike_out), 64'(m_spout));
    if (spike_valid) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL spike_valid cycle %0d: got 1 expected 0", cyc);
      end else begin
        e = q.pop_front();
        chk("spike_latency", 64'(cyc), 64'(e.due));
        chk("spike_out", 64'(spike_out), 64'(e.sp));
        for (int i = 0; i < N; i++) chk($sformatf("mem[%0d]", i), 64'(dut.mem_q[i]), 64'(e.mem[i]));
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    mon_en = 1;
    chk("reset_spike_valid", 64'(spike_valid), 64'd0);

    // Reset mid-sweep, then an empty timestep
    step(0, 1, 3, 200, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    idle(2);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_spike_out", 64'(spike_out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    step(0, 0, 0, 0, 1, 0);
    idle(6);

    // Fire then leak on ch0, negative integration on ch1
    step(0, 1, 0, 60, 0, 0);
    step(0, 1, 0, 50, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    idle(6);
    step(0, 0, 0, 0, 1, 0);
    idle(6);
    step(0, 1, 1, -50, 1, 0);
    idle(6);
    step(0, 0, 0, 0, 1, 0);
    idle(6);

    // Overrun: psum and transit during the sweep are dropped
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 30, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    idle(6);
    step(0, 1, 0, 500, 1, 0);
    idle(6);
    step(1, 0, 0, 0, 0, 0);

    // Saturation on ch2
    step(0, 1, 2, 64'h7FFFFFF0, 0, 0);
    step(0, 1, 2, 64'h7FFFFFF0, 0, 0);
    chk("acc2_sat", 64'(dut.acc_q[2]), 64'(m_acc[2][31:0]));
    chk("acc2_sat_const", 64'(dut.acc_q[2]), 64'h7FFFFFFF);
    step(0, 0, 0, 0, 1, 0);
    idle(6);

    // Out-of-range index ignored, sample_rst abort, sample_rst+psum+transit in idle
    step(0, 1, 5, 1000, 0, 0);
    step(0, 1, 3, 150, 1, 0);
    idle(2);
    step(0, 0, 0, 0, 0, 1);
    idle(3);
    step(0, 1, 0, 300, 0, 0);
    step(0, 1, 0, 300, 1, 1);
    idle(6);

    for (int k = 0; k < 600; k++) begin
      longint p;
      bit v, tr, sr, r;
      p  = ($urandom_range(0, 19) == 0) ? longint'(signed'($urandom()))
                                         : longint'($urandom_range(0, 300)) - 150;
      v  = ($urandom_range(0, 9) < 6);
      tr = ($urandom_range(0, 9) == 0);
      sr = ($urandom_range(0, 39) == 0);
      r  = ($urandom_range(0, 149) == 0);
      step(r, v, int'($urandom_range(0, 7)), p, tr, sr);
    end
    idle(8);
    chk("queue_drained", 64'(q.size()), 64'd0);
    mon_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
